// File: rtl/mult_arbiter.sv
// Round-robin sharing of one pipelined 32x32 multiplier between two requesters, with per-requester flush.
// Latency: accept edge k -> resp_valid at edge k+MUL_LAT; one op per cycle; results in issue order.
// Backpressure: req_ready is the combinational grant; responses cannot be stalled.
module mult_arbiter #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_src0,
    input  logic [63:0] req_src1,
    input  logic [1:0]  req_op,
    input  logic [1:0]  flush,
    output logic [31:0] mul_src0,
    output logic [31:0] mul_src1,
    output logic        mul_op,
    input  logic [63:0] mul_res,
    output logic [1:0]  resp_valid,
    output logic [63:0] resp_res,
    output logic        busy
);

    logic               prio;      // requester preferred when both are eligible
    logic [1:0]         elig;
    logic [1:0]         grant;
    logic               accept;
    logic               win_id;
    logic [MUL_LAT-1:0] tag_vld;
    logic [MUL_LAT-1:0] tag_id;
    logic [MUL_LAT-1:0] tag_live;
    logic               fire;

    always_comb begin
        elig  = rst ? 2'b00 : (req_valid & ~flush);
        grant = elig;
        if (elig == 2'b11) begin
            grant = prio ? 2'b10 : 2'b01;
        end
        accept = |grant;
        win_id = grant[1];
    end

    assign req_ready = grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio     <= 1'b0;
            mul_src0 <= '0;
            mul_src1 <= '0;
            mul_op   <= 1'b0;
        end else if (accept) begin
            prio     <= ~win_id;
            mul_src0 <= win_id ? req_src0[63:32] : req_src0[31:0];
            mul_src1 <= win_id ? req_src1[63:32] : req_src1[31:0];
            mul_op   <= req_op[win_id];
        end
    end

    // Tags travel alongside the multiplier pipe; a flush clears live as each tag advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld  <= '0;
            tag_id   <= '0;
            tag_live <= '0;
        end else begin
            tag_vld[0]  <= accept;
            tag_id[0]   <= win_id;
            tag_live[0] <= 1'b1;
            for (int j = 1; j < MUL_LAT; j++) begin
                tag_vld[j]  <= tag_vld[j-1];
                tag_id[j]   <= tag_id[j-1];
                tag_live[j] <= tag_live[j-1] & ~flush[tag_id[j-1]];
            end
        end
    end

    // The tag aligned with mul_res this cycle can still be killed by a same-cycle flush.
    assign fire = tag_vld[MUL_LAT-1] & tag_live[MUL_LAT-1] & ~flush[tag_id[MUL_LAT-1]];

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 2'b00;
            resp_res   <= '0;
        end else begin
            resp_valid <= fire ? {tag_id[MUL_LAT-1], ~tag_id[MUL_LAT-1]} : 2'b00;
            if (fire) begin
                resp_res <= mul_res;
            end
        end
    end

    assign busy = |tag_vld;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed stimulus, arbitration model at negedge, response scoreboard after posedge.
module tb_mult_arbiter #(
    parameter int L = 2
);

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_src0;
    logic [63:0] req_src1;
    logic [1:0]  req_op;
    logic [1:0]  flush;
    logic [31:0] mul_src0;
    logic [31:0] mul_src1;
    logic        mul_op;
    logic [63:0] mul_res;
    logic [1:0]  resp_valid;
    logic [63:0] resp_res;
    logic        busy;

    typedef struct {
        logic        id;
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic        prio_m = 1'b0;
    logic [63:0] exp0, exp1;

    mult_arbiter #(.MUL_LAT(L)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src0(req_src0), .req_src1(req_src1), .req_op(req_op), .flush(flush),
        .mul_src0(mul_src0), .mul_src1(mul_src1), .mul_op(mul_op), .mul_res(mul_res),
        .resp_valid(resp_valid), .resp_res(resp_res), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External multiplier: product of the registered operands, L-1 further register stages.
    logic [63:0] prod;
    logic signed [63:0] sa, sb;
    always_comb begin
        sa = {{32{mul_src0[31]}}, mul_src0};
        sb = {{32{mul_src1[31]}}, mul_src1};
        prod = mul_op ? 64'(sa * sb) : ({32'b0, mul_src0} * {32'b0, mul_src1});
    end

    generate
        if (L == 1) begin : g_comb
            assign mul_res = prod;
        end else begin : g_pipe
            logic [63:0] mp [L-1];
            always @(posedge clk) begin
                mp[0] <= prod;
                for (int j = 1; j < L - 1; j++) mp[j] <= mp[j-1];
            end
            assign mul_res = mp[L-2];
        end
    endgenerate

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exv);
        n_chk++;
        if (act !== exv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exv, cyc);
        end
    endtask

    // Arbitration model: checks the grant and records the expected response.
    always @(negedge clk) begin
        logic [1:0] el, g;
        exp_t e;
        if (rst) begin
            chk("ready_in_reset", 64'(req_ready), 64'd0);
            q.delete();
            prio_m = 1'b0;
        end else begin
            el = req_valid & ~flush;
            g  = el;
            if (el == 2'b11) g = prio_m ? 2'b10 : 2'b01;
            chk("grant", 64'(req_ready), 64'(g));
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (flush[q[i].id]) q.delete(i);
            end
            if (g != 2'b00) begin
                e.id  = g[1];
                e.res = g[1] ? exp1 : exp0;
                e.cyc = cyc + 1 + L;
                q.push_back(e);
                prio_m = ~g[1];
            end
        end
    end

    // Response monitor.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (resp_valid != 2'b00) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_resp: got resp_valid %b expected none (cycle %0d)", resp_valid, cyc);
            end else begin
                e = q.pop_front();
                chk("resp_valid", 64'(resp_valid), 64'({e.id, ~e.id}));
                chk("resp_res", resp_res, e.res);
                chk("resp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missing_resp: got none expected id %0d res %h (cycle %0d)", e.id, e.res, cyc);
        end
    end

    task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [1:0] op,
                         input logic [1:0] fl, input logic [63:0] e0, input logic [63:0] e1);
        req_valid = v;
        req_src0  = {a1, a0};
        req_src1  = {b1, b0};
        req_op    = op;
        flush     = fl;
        exp0      = e0;
        exp1      = e1;
        @(posedge clk);
        #2;
        req_valid = 2'b00;
        flush     = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_valid = 2'b11; req_src0 = '1; req_src1 = '1;
        req_op = 2'b11; flush = 2'b00; exp0 = '0; exp1 = '0;
        idle(2);
        chk("rst_mul_src0", 64'(mul_src0), 64'd0);
        chk("rst_mul_src1", 64'(mul_src1), 64'd0);
        chk("rst_mul_op", 64'(mul_op), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_res", resp_res, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0; req_valid = 2'b00;
        idle(1);

        // Single op, signed then unsigned
        drive(2'b01, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 2'b01, 2'b00, 64'hFFFFFFFF_FFFFFFFE, 64'd0);
        chk("issue_src0", 64'(mul_src0), 64'hFFFFFFFF);
        chk("issue_src1", 64'(mul_src1), 64'd2);
        chk("issue_op", 64'(mul_op), 64'd1);
        chk("busy_inflight", 64'(busy), 64'd1);
        idle(L + 2);
        chk("busy_idle", 64'(busy), 64'd0);
        drive(2'b01, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 2'b00, 2'b00, 64'h00000001_FFFFFFFE, 64'd0);
        chk("hold_src0", 64'(mul_src0), 64'hFFFFFFFF);
        idle(L + 2);

        // Only requester 1, then both contending, back to back
        for (int i = 0; i < 4; i++)
            drive(2'b10, 32'd0, 32'd0, 32'(i + 2), 32'd5, 2'b00, 2'b00, 64'd0, 64'((i + 2) * 5));
        for (int i = 0; i < 6; i++)
            drive(2'b11, 32'(i + 1), 32'd3, 32'(-(i + 1)), 32'd3, 2'b10, 2'b00,
                  64'((i + 1) * 3), 64'(-3 * (i + 1)));
        idle(L + 2);

        // Flush blocks a same-cycle accept of the flushed requester only
        drive(2'b11, 32'd4, 32'd4, 32'd5, 32'd5, 2'b00, 2'b01, 64'd16, 64'd25);
        idle(L + 2);

        // Flush of an in-flight op; the other requester completes
        drive(2'b01, 32'd7, 32'd9, 32'd0, 32'd0, 2'b00, 2'b00, 64'd63, 64'd0);
        drive(2'b10, 32'd0, 32'd0, 32'd3, 32'd5, 2'b00, 2'b01, 64'd0, 64'd15);
        idle(L + 2);
        chk("busy_after_flush", 64'(busy), 64'd0);

        // Flush in the cycle the result is aligned with mul_res
        drive(2'b01, 32'd6, 32'd7, 32'd0, 32'd0, 2'b00, 2'b00, 64'd42, 64'd0);
        idle(L - 1);
        drive(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b01, 64'd0, 64'd0);
        idle(L + 2);

        // Reset with two ops in flight
        drive(2'b01, 32'd2, 32'd3, 32'd0, 32'd0, 2'b00, 2'b00, 64'd6, 64'd0);
        drive(2'b10, 32'd0, 32'd0, 32'd4, 32'd5, 2'b00, 2'b00, 64'd0, 64'd20);
        rst = 1'b1;
        idle(1);
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_src0", 64'(mul_src0), 64'd0);
        chk("midrst_src1", 64'(mul_src1), 64'd0);
        rst = 1'b0;
        idle(L + 3);
        drive(2'b01, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 2'b01, 2'b00, 64'hFFFFFFFF_FFFFFFFE, 64'd0);
        idle(L + 3);

        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
